// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, constants and the fetch-entry type for the MIPS pipeline
package mips_pipe_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pcplus4;
  } fetch_entry_t;
endpackage

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo: synchronous FIFO with flush, occupancy count and simultaneous push/pop
// Any DEPTH >= 1 works; pointers wrap explicitly rather than relying on a power of two.
module mips_fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic full, empty, do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + AW'(1);
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr] <= push_data;
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop && !flush));
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: decoupled instruction fetch with in-flight requests, prefetch FIFO and ID redirect
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module mips_fetch_unit
  import mips_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int TW = $clog2(MAX_OUTST) + 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pcplus4,
  output logic [CW-1:0]      fifo_count,
  output logic [31:0]        perf_redirects,
  output logic [31:0]        perf_starve
);
  logic [XLEN-1:0] pc, tag_pc, head_pc4;
  logic [INSTR_W-1:0] head_instr;
  logic [TW-1:0] outst, discard;
  logic acc, drop, push, pop, credit;
  // Occupancy of the tag queue is exactly the number of requests in flight.
  assign credit = int'(fifo_count) + int'(outst) - int'(discard) < FIFO_DEPTH;
  assign imem_req_valid = reset && !redirect_valid && int'(outst) < MAX_OUTST && credit;
  assign imem_req_addr = pc;
  assign acc = imem_req_valid && imem_req_ready;
  assign drop = imem_rsp_valid && discard != '0;
  assign push = imem_rsp_valid && !drop && !redirect_valid;
  assign pop = id_valid && id_ready && !redirect_valid;
  assign id_valid = fifo_count != '0;
  assign id_instr = id_valid ? head_instr : NOP;
  assign id_pcplus4 = id_valid ? head_pc4 : '0;
  mips_fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUTST)) u_tags (
    .clk(clk), .reset(reset), .flush(1'b0), .push(acc), .push_data(pc),
    .pop(imem_rsp_valid), .head(tag_pc), .count(outst)
  );
  mips_fetch_fifo #(.W(INSTR_W + XLEN), .DEPTH(FIFO_DEPTH)) u_prefetch (
    .clk(clk), .reset(reset), .flush(redirect_valid), .push(push),
    .push_data({imem_rsp_data, tag_pc + XLEN'(4)}), .pop(pop),
    .head({head_instr, head_pc4}), .count(fifo_count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_PC;
      discard <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~XLEN'(3);
      discard <= outst - TW'(imem_rsp_valid);
    end else begin
      if (acc) pc <= pc + XLEN'(4);
      if (drop) discard <= discard - TW'(1);
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_redirects <= '0;
      perf_starve <= '0;
    end else begin
      if (redirect_valid) perf_redirects <= perf_redirects + 32'd1;
      if (id_ready && !id_valid && !redirect_valid) perf_starve <= perf_starve + 32'd1;
    end
`else
  assign perf_redirects = '0;
  assign perf_starve = '0;
`endif
endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. It replaces the bare PC register, PC adder and asynchronous instruction-memory read with a decoupled unit.
- Features: valid/ready request/response interface to instruction memory with multiple requests in flight, a prefetch FIFO toward IF/ID, and a redirect path for branches and jumps resolved in ID.
- Sits between instruction memory and the IF/ID register. The hazard unit stalls fetch through `id_ready`.

Parameters:
- XLEN, 32, address/PC width; must be ≥ 8.
- FIFO_DEPTH, 4, prefetch entries; power of 2, ≥ 2.
- MAX_OUTST, 2, maximum outstanding memory requests; 1..FIFO_DEPTH.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; responses return in order, one cycle or more after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  ID-resolved taken branch or jump (pcsrcD | jump).
- redirect_pc  input  XLEN  target address; bits [1:0] ignored.
- id_valid  output  1  FIFO head valid.
- id_ready  input  1  IF/ID consumes head (low = stallD).
- id_instr  output  32  head instruction.
- id_pcplus4  output  XLEN  head PC + 4.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy.
- perf_redirects  output  32  redirect counter (see Optional Feature).
- perf_starve  output  32  starve counter (see Optional Feature).

Behaviour:
- Reset (async, active low):
  - pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - All outputs 0 except imem_req_addr = RESET_PC.
  - The first request is issued in the first cycle after reset deasserts.
- Request issue:
  - imem_req_valid = !redirect_valid && outstanding < MAX_OUTST && (fifo_count + outstanding − discard) < FIFO_DEPTH.
  - imem_req_addr = pc.
  - An accept is valid && ready. On an accept: pc += 4 (mod 2^XLEN, wraps silently) and outstanding increments.
  - Each accepted request records its PC in an in-order tag queue of depth MAX_OUTST.
- Response:
  - On imem_rsp_valid, outstanding decrements.
  - If discard > 0, the response is dropped and discard decrements.
  - Otherwise {data, tag_pc+4} is pushed to the FIFO.
  - The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- ID handshake: pop when id_valid && id_ready. Push and pop may occur in the same cycle, including when the FIFO is full or empty. The head output is combinational from FIFO storage.
- Latency: with single-cycle memory and id_ready = 1, the first id_valid appears 2 cycles after reset release. After that, one instruction per cycle is delivered.
- Redirect (single cycle, highest priority):
  - FIFO flushed, so id_valid = 0 next cycle.
  - A pop in the same cycle is ignored.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued that cycle.
  - discard <= outstanding − (rsp_valid && discard == 0 ? 1 : 0) − (rsp_valid && discard > 0 ? 1 : 0). That is, every request still in flight after this cycle is dropped.
  - Back-to-back redirects: the last one wins.
- Stall: id_ready low holds the FIFO. Requests continue until credits are exhausted, then imem_req_valid drops.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_redirects counts redirect_valid cycles.
  - perf_starve counts cycles with id_ready && !id_valid && !redirect_valid.
  - Both are 32-bit, wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package mips_pipe_pkg holds:
  - XLEN_DEFAULT = 32.
  - INSTR_W = 32.
  - NOP = 32'h0000_0000.
  - RESET_PC_DEFAULT = 0.
  - A fetch-entry typedef {instr, pcplus4}.
- One sub-module, mips_fetch_fifo: a parametrised synchronous FIFO with flush, count, and simultaneous push/pop. It is instantiated for the prefetch buffer and reused for the tag queue.

Test Plan:
- Reset release, 1-cycle memory, id_ready = 1 → imem_req_addr sequence 0x0, 0x4, 0x8…; first id_valid at cycle 2 with id_pcplus4 = 0x4; then one instruction per cycle.
- id_ready = 0 for 10 cycles, FIFO_DEPTH = 4 → fifo_count saturates at 4 and imem_req_valid deasserts. On release, four instructions come out in order (0x0..0xC) before the next one.
- Redirect to 0x40 while 2 requests are outstanding at 3-cycle latency → both responses are dropped, next id_instr has id_pcplus4 = 0x44, and no stale instruction appears.
- Redirect and rsp_valid in the same cycle with discard = 0 → that response is dropped, discard = outstanding − 1, and the sequence resumes at the target.
- Assert reset mid-stream with 2 in flight → all outputs clear asynchronously and fetch restarts at RESET_PC.
- With FETCH_PERF_EN, 3 redirects plus 5 starve cycles → perf_redirects = 3, perf_starve = 5. Without the macro, both read 0.
